pointer_basic_feeder: RTL and testbench

Upstream feeder stage for the `pointer_basic` HLS core. Accepts 32-bit samples from a valid/ready stream into a small FIFO, then for each sample runs one complete core invocation: drives `ap_start` (ap_ctrl_hs) and presents the sample on `d_i` with `d_i_ap_vld` (ap_hs), holding both until the core completes the respective handshakes. Sits between the testbench/stream source and the core's `ap_start`/`d_i` ports. The `d_o` side is consumed elsewhere.

---
 rtl/pointer_basic_feeder.sv | 132 +++++++++++++
 tb/tb_pointer_basic_feeder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pointer_basic_feeder.sv
// Upstream feeder for the pointer_basic HLS core: buffers stream samples in a small FIFO
// and runs one ap_ctrl_hs invocation per sample, presenting it on the ap_hs d_i port.
module pointer_basic_feeder #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [DW-1:0]                s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         ap_start,
    input  logic                         ap_ready,
    output logic [DW-1:0]                d_i,
    output logic                         d_i_ap_vld,
    input  logic                         d_i_ap_ack,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [31:0]                  issued_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            load;
    logic            complete;
    logic            push;
    logic            pop;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [DW-1:0]   mem [DEPTH];

    // Space is judged on the registered level only, so a same-cycle pop never frees a slot.
    assign s_ready = (fifo_level != LW'(DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = d_i_ap_vld && d_i_ap_ack;

    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

    // The two handshakes retire independently; the invocation completes when the second one lands.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    state_next = ISSUE;
                    load       = 1'b1;
                end
            end
            ISSUE: begin
                if (ap_ready && d_i_ap_ack) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end else if (d_i_ap_ack) begin
                    state_next = WAIT_RDY;
                end else if (ap_ready) begin
                    state_next = WAIT_ACK;
                end
            end
            WAIT_RDY: begin
                if (ap_ready) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (d_i_ap_ack) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            ap_start   <= 1'b0;
            d_i_ap_vld <= 1'b0;
            d_i        <= '0;
            issued_cnt <= '0;
        end else begin
            state      <= state_next;
            ap_start   <= (state_next == ISSUE) || (state_next == WAIT_RDY);
            d_i_ap_vld <= (state_next == ISSUE) || (state_next == WAIT_ACK);
            if (load) begin
                d_i <= mem[rd_ptr];
            end
            if (complete) begin
                issued_cnt <= issued_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pointer_basic_feeder.sv
// Self-checking bench for pointer_basic_feeder: a cycle table for the handshake corners,
// then hand-written fill, streaming and mid-transaction reset sequences.
module tb_pointer_basic_feeder;

    typedef struct {
        logic        s_valid;
        logic [31:0] s_data;
        logic        ap_ready;
        logic        d_i_ap_ack;
        logic        exp_start;
        logic        exp_vld;
        logic [31:0] exp_d_i;
        logic [2:0]  exp_level;
        logic [31:0] exp_cnt;
    } vec_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        ap_start;
    logic        ap_ready = 1'b0;
    logic [31:0] d_i;
    logic        d_i_ap_vld;
    logic        d_i_ap_ack = 1'b0;
    logic [2:0]  fifo_level;
    logic [31:0] issued_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] pop_data[$];
    int          pop_cyc[$];
    vec_t        vecs[22];

    pointer_basic_feeder #(.DW(32), .DEPTH(4)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .d_i        (d_i),
        .d_i_ap_vld (d_i_ap_vld),
        .d_i_ap_ack (d_i_ap_ack),
        .fifo_level (fifo_level),
        .issued_cnt (issued_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    // Records every consumed sample and the cycle it was consumed on.
    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (ap_rst_n && d_i_ap_vld && d_i_ap_ack) begin
            pop_data.push_back(d_i);
            pop_cyc.push_back(cyc);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic stepCycle;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        s_valid    = v.s_valid;
        s_data     = v.s_data;
        ap_ready   = v.ap_ready;
        d_i_ap_ack = v.d_i_ap_ack;
        stepCycle();
        checkOutput($sformatf("row%0d_start", idx), 32'(ap_start), 32'(v.exp_start));
        checkOutput($sformatf("row%0d_vld", idx), 32'(d_i_ap_vld), 32'(v.exp_vld));
        checkOutput($sformatf("row%0d_d_i", idx), d_i, v.exp_d_i);
        checkOutput($sformatf("row%0d_level", idx), 32'(fifo_level), 32'(v.exp_level));
        checkOutput($sformatf("row%0d_cnt", idx), issued_cnt, v.exp_cnt);
        checkOutput($sformatf("row%0d_s_ready", idx), 32'(s_ready), 32'(v.exp_level != 3'd4));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_start"}, 32'(ap_start), 32'd0);
        checkOutput({tag, "_vld"}, 32'(d_i_ap_vld), 32'd0);
        checkOutput({tag, "_d_i"}, d_i, 32'd0);
        checkOutput({tag, "_level"}, 32'(fifo_level), 32'd0);
        checkOutput({tag, "_cnt"}, issued_cnt, 32'd0);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    endtask

    task automatic doReset(input string tag);
        ap_rst_n   = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        ap_ready   = 1'b0;
        d_i_ap_ack = 1'b0;
        repeat (2) stepCycle();
        checkResetValues(tag);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        pop_data.delete();
        pop_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // s_valid, s_data, ap_ready, ack | start, vld, d_i, level, cnt
        vecs[0]  = '{1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'd1, 32'd0};
        vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 3'd1, 32'd0};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 3'd1, 32'd0};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 3'd1, 32'd0};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 3'd0, 32'd1};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 3'd0, 32'd1};
        vecs[6]  = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 3'd1, 32'd1};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 3'd1, 32'd1};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA, 3'd0, 32'd1};
        vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA, 3'd0, 32'd1};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA, 3'd0, 32'd1};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA, 3'd0, 32'd2};
        vecs[12] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA, 3'd1, 32'd2};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB, 3'd1, 32'd2};
        vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 3'd1, 32'd2};
        vecs[15] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 3'd1, 32'd2};
        vecs[16] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB, 3'd1, 32'd2};
        vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB, 3'd0, 32'd3};
        vecs[18] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hB, 3'd0, 32'd3};
        vecs[19] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB, 3'd0, 32'd3};
        vecs[20] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hB, 3'd0, 32'd3};
        vecs[21] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hB, 3'd0, 32'd3};

        doReset("reset0");
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Fill to four words with the core stalled; the fifth must be held off.
        doReset("reset1");
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            stepCycle();
        end
        s_data = 32'd5;
        for (int i = 0; i < 3; i++) begin
            checkOutput("full_level", 32'(fifo_level), 32'd4);
            checkOutput("full_s_ready", 32'(s_ready), 32'd0);
            stepCycle();
        end
        checkOutput("full_d_i", d_i, 32'd1);
        ap_ready   = 1'b1;
        d_i_ap_ack = 1'b1;
        for (int i = 0; i < 60 && issued_cnt != 32'd5; i++) begin
            automatic logic acc = s_valid && s_ready;
            stepCycle();
            if (acc) s_valid = 1'b0;
        end
        checkOutput("fill_cnt", issued_cnt, 32'd5);
        checkOutput("fill_level", 32'(fifo_level), 32'd0);
        checkOutput("fill_pops", 32'(pop_data.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < pop_data.size()) checkOutput($sformatf("fill_order%0d", k), pop_data[k], 32'(k + 1));
        end

        // Core always ready: one invocation every two cycles, order preserved.
        doReset("reset2");
        ap_ready   = 1'b1;
        d_i_ap_ack = 1'b1;
        begin
            automatic int sent = 0;
            for (int i = 0; i < 200 && issued_cnt != 32'd16; i++) begin
                automatic logic acc;
                s_valid = (sent < 16);
                s_data  = 32'hC0DE_0000 + 32'(sent);
                acc = s_valid && s_ready;
                stepCycle();
                if (acc) sent++;
            end
            s_valid = 1'b0;
        end
        checkOutput("b2b_cnt", issued_cnt, 32'd16);
        checkOutput("b2b_pops", 32'(pop_data.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < pop_data.size()) checkOutput($sformatf("b2b_order%0d", k), pop_data[k], 32'hC0DE_0000 + 32'(k));
            if (k > 0 && k < pop_cyc.size()) checkOutput($sformatf("b2b_gap%0d", k), 32'(pop_cyc[k] - pop_cyc[k-1]), 32'd2);
        end

        // Asynchronous reset with three words buffered and an invocation outstanding.
        doReset("reset3");
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h50 + 32'(i);
            stepCycle();
        end
        s_valid = 1'b0;
        checkOutput("pre_rst_start", 32'(ap_start), 32'd1);
        checkOutput("pre_rst_level", 32'(fifo_level), 32'd3);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("post_rst_start", 32'(ap_start), 32'd0);
            checkOutput("post_rst_level", 32'(fifo_level), 32'd0);
        end
        s_valid = 1'b1;
        s_data  = 32'h77;
        stepCycle();
        s_valid = 1'b0;
        stepCycle();
        checkOutput("post_rst_new_start", 32'(ap_start), 32'd1);
        checkOutput("post_rst_new_d_i", d_i, 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
